pcie_rx_tlp_parser: RTL and testbench



---
 rtl/pcie_rx_tlp_parser_if.sv | 44 ++++
 rtl/pcie_rx_tlp_parser.sv | 191 +++++++++++++++++++
 tb/tb_pcie_rx_tlp_parser.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_rx_tlp_parser_if.sv
// Bundles the bridge Rx stream, write-beat, read-descriptor and status signals of
// pcie_rx_tlp_parser; the parser is the slave, the bridge/consumer side is the master.
interface pcie_rx_tlp_parser_if;
  logic [31:0] i_axis_rx_tdata;
  logic [3:0]  i_axis_rx_tkeep;
  logic        i_axis_rx_tlast;
  logic        i_axis_rx_tvalid;
  logic        o_axis_rx_tready;
  logic [21:0] i_axis_rx_tuser;
  logic [63:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic [3:0]  o_wr_be;
  logic        o_wr_last;
  logic        o_wr_valid;
  logic        i_wr_ready;
  logic [63:0] o_rd_addr;
  logic [10:0] o_rd_len;
  logic [7:0]  o_rd_tag;
  logic [15:0] o_rd_req_id;
  logic [2:0]  o_rd_tc;
  logic [1:0]  o_rd_attr;
  logic [3:0]  o_rd_first_be;
  logic [3:0]  o_rd_last_be;
  logic        o_rd_valid;
  logic        i_rd_ready;
  logic [6:0]  o_bar_hit;
  logic [15:0] o_drop_count;

  modport slave (
    input  i_axis_rx_tdata, i_axis_rx_tkeep, i_axis_rx_tlast, i_axis_rx_tvalid,
    input  i_axis_rx_tuser, i_wr_ready, i_rd_ready,
    output o_axis_rx_tready, o_wr_addr, o_wr_data, o_wr_be, o_wr_last, o_wr_valid,
    output o_rd_addr, o_rd_len, o_rd_tag, o_rd_req_id, o_rd_tc, o_rd_attr,
    output o_rd_first_be, o_rd_last_be, o_rd_valid, o_bar_hit, o_drop_count
  );

  modport master (
    output i_axis_rx_tdata, i_axis_rx_tkeep, i_axis_rx_tlast, i_axis_rx_tvalid,
    output i_axis_rx_tuser, i_wr_ready, i_rd_ready,
    input  o_axis_rx_tready, o_wr_addr, o_wr_data, o_wr_be, o_wr_last, o_wr_valid,
    input  o_rd_addr, o_rd_len, o_rd_tag, o_rd_req_id, o_rd_tc, o_rd_attr,
    input  o_rd_first_be, o_rd_last_be, o_rd_valid, o_bar_hit, o_drop_count
  );
endinterface

// File: rtl/pcie_rx_tlp_parser.sv
// Rx TLP parser: MWr payload -> addr/data/be beats, MRd -> held descriptor, all else dropped
// and counted. Define RX_TLP_PARSER_64BIT_ADDR_EN to decode 4DW (64-bit address) requests.
module pcie_rx_tlp_parser #(
  parameter logic [6:0] BAR_MASK = 7'h7F
) (
  input logic                  clk,
  input logic                  rst,
  pcie_rx_tlp_parser_if.slave  bus
);
  typedef enum logic [2:0] {S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_DATA, S_RD_HOLD, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] dw;
  logic        tlast, accept, tready, dw0_ok, fmt_ok, final_beat, drop_inc;
  logic        is_wr_q, is_4dw_q, rd_drop_q, rd_drop_d;
  logic [10:0] len_q, cnt_q;
  logic [2:0]  tc_q;
  logic [1:0]  attr_q;
  logic [15:0] req_id_q, drop_count_q;
  logic [7:0]  tag_q;
  logic [3:0]  first_be_q, last_be_q, wr_be_q;
  logic [63:0] addr_q, wr_addr_q;
  logic [31:0] wr_data_q;
  logic        wr_last_q, wr_valid_q, rd_valid_q;
  logic [6:0]  bar_hit_q;
  logic        unused_ok;

  assign dw    = bus.i_axis_rx_tdata;
  assign tlast = bus.i_axis_rx_tlast;
  assign unused_ok = ^{bus.i_axis_rx_tkeep, bus.i_axis_rx_tuser[21:9]};

`ifdef RX_TLP_PARSER_64BIT_ADDR_EN
  assign fmt_ok = 1'b1;
`else
  assign fmt_ok = ~dw[29];
`endif
  assign dw0_ok = fmt_ok && (dw[28:24] == 5'd0) && !dw[14] && !bus.i_axis_rx_tuser[1] &&
                  !bus.i_axis_rx_tuser[0] && ((bus.i_axis_rx_tuser[8:2] & BAR_MASK) != 7'd0);
  assign final_beat = (cnt_q == len_q - 11'd1);

  always_comb begin
    state_d   = state_q;
    tready    = 1'b0;
    accept    = 1'b0;
    drop_inc  = 1'b0;
    rd_drop_d = rd_drop_q;
    case (state_q)
      S_DATA:    tready = !wr_valid_q || bus.i_wr_ready;
      S_RD_HOLD: tready = 1'b0;
      default:   tready = 1'b1;
    endcase
    if (rst) tready = 1'b0;
    accept = bus.i_axis_rx_tvalid && tready;
    if (accept) begin
      case (state_q)
        S_HDR0: begin
          if (!dw0_ok || tlast) drop_inc = 1'b1;
          if (!tlast) state_d = dw0_ok ? S_HDR1 : S_DROP;
        end
        S_HDR1: begin
          drop_inc = tlast;
          state_d  = tlast ? S_HDR0 : S_HDR2;
        end
        S_HDR2, S_HDR3: begin
          if (state_q == S_HDR2 && is_4dw_q) begin
            drop_inc = tlast;
            state_d  = tlast ? S_HDR0 : S_HDR3;
          end else if (is_wr_q) begin
            drop_inc = tlast;
            state_d  = tlast ? S_HDR0 : S_DATA;
          end else begin
            // A read carrying payload is still served, then its tail is flushed.
            state_d   = S_RD_HOLD;
            rd_drop_d = !tlast;
            drop_inc  = !tlast;
          end
        end
        S_DATA: begin
          if (tlast) begin
            state_d  = S_HDR0;
            drop_inc = !final_beat;
          end else if (final_beat) begin
            state_d = S_DROP;
          end
        end
        S_DROP: if (tlast) state_d = S_HDR0;
        default: ;
      endcase
    end
    if (state_q == S_RD_HOLD && bus.i_rd_ready) begin
      state_d   = rd_drop_q ? S_DROP : S_HDR0;
      rd_drop_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HDR0;
      is_wr_q      <= 1'b0;
      is_4dw_q     <= 1'b0;
      rd_drop_q    <= 1'b0;
      len_q        <= '0;
      cnt_q        <= '0;
      tc_q         <= '0;
      attr_q       <= '0;
      req_id_q     <= '0;
      tag_q        <= '0;
      first_be_q   <= '0;
      last_be_q    <= '0;
      addr_q       <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_be_q      <= '0;
      wr_last_q    <= 1'b0;
      wr_valid_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      bar_hit_q    <= '0;
      drop_count_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_drop_q <= rd_drop_d;
      if (drop_inc) drop_count_q <= drop_count_q + 16'd1;
      if (wr_valid_q && bus.i_wr_ready) wr_valid_q <= 1'b0;
      if (state_q == S_RD_HOLD && bus.i_rd_ready) rd_valid_q <= 1'b0;
      if (accept && state_d == S_RD_HOLD) rd_valid_q <= 1'b1;
      if (accept) begin
        case (state_q)
          S_HDR0: begin
            bar_hit_q <= bus.i_axis_rx_tuser[8:2];
            is_wr_q   <= dw[30];
            is_4dw_q  <= dw[29];
            tc_q      <= dw[22:20];
            attr_q    <= dw[13:12];
            len_q     <= {(dw[9:0] == 10'd0), dw[9:0]};
          end
          S_HDR1: begin
            req_id_q   <= dw[31:16];
            tag_q      <= dw[15:8];
            last_be_q  <= dw[7:4];
            first_be_q <= dw[3:0];
          end
          S_HDR2: begin
            cnt_q <= '0;
`ifdef RX_TLP_PARSER_64BIT_ADDR_EN
            if (is_4dw_q) addr_q <= {dw, 32'h0};
            else          addr_q <= {32'h0, dw[31:2], 2'b00};
`else
            addr_q <= {32'h0, dw[31:2], 2'b00};
`endif
          end
          S_HDR3: begin
            cnt_q        <= '0;
            addr_q[31:0] <= {dw[31:2], 2'b00};
          end
          S_DATA: begin
            wr_valid_q <= 1'b1;
            wr_data_q  <= dw;
            wr_addr_q  <= addr_q;
            wr_be_q    <= (cnt_q == 11'd0) ? first_be_q : (final_beat ? last_be_q : 4'hF);
            wr_last_q  <= final_beat || tlast;
            cnt_q      <= cnt_q + 11'd1;
`ifdef RX_TLP_PARSER_64BIT_ADDR_EN
            addr_q <= addr_q + 64'd4;
`else
            addr_q <= {32'h0, addr_q[31:0] + 32'd4};
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_axis_rx_tready = tready;
  assign bus.o_wr_addr     = wr_addr_q;
  assign bus.o_wr_data     = wr_data_q;
  assign bus.o_wr_be       = wr_be_q;
  assign bus.o_wr_last     = wr_last_q;
  assign bus.o_wr_valid    = wr_valid_q;
  assign bus.o_rd_addr     = addr_q;
  assign bus.o_rd_len      = len_q;
  assign bus.o_rd_tag      = tag_q;
  assign bus.o_rd_req_id   = req_id_q;
  assign bus.o_rd_tc       = tc_q;
  assign bus.o_rd_attr     = attr_q;
  assign bus.o_rd_first_be = first_be_q;
  assign bus.o_rd_last_be  = last_be_q;
  assign bus.o_rd_valid    = rd_valid_q;
  assign bus.o_bar_hit     = bar_hit_q;
  assign bus.o_drop_count  = drop_count_q;
endmodule

// File: tb/tb_pcie_rx_tlp_parser.sv
// Directed bench for pcie_rx_tlp_parser: a packet-level model turns each TLP into expected
// write beats, read descriptors and drop counts; a negedge monitor checks the DUT against it.
module tb_pcie_rx_tlp_parser;
  localparam logic [6:0] BAR_MASK = 7'h7F;

  typedef struct packed {
    logic [63:0] addr; logic [31:0] data; logic [3:0] be; logic last;
  } wr_t;
  typedef struct packed {
    logic [63:0] addr; logic [10:0] len; logic [7:0] tag; logic [15:0] req_id;
    logic [2:0] tc; logic [1:0] attr; logic [3:0] fb; logic [3:0] lb;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pcie_rx_tlp_parser_if bus();

  pcie_rx_tlp_parser #(.BAR_MASK(BAR_MASK)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  int    wr_mode = 0;
  logic  mon_en = 1'b0;
  logic [15:0] model_drops = 16'd0;
  wr_t   exp_wr[$];
  rd_t   exp_rd[$];
  wr_t   got_wr[$];
  logic [31:0] pkt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Packet-level reference: what a whole TLP must produce, independent of cycle timing.
  function automatic void model_tlp(input logic [31:0] p[$], input logic [21:0] u);
    logic [31:0] d0, d1, d2, d3;
    int n, hn, plen, pay;
    logic ok;
    logic [63:0] a;
    wr_t w;
    rd_t r;
    n  = p.size();
    d0 = p[0];
    d1 = (n > 1) ? p[1] : 32'h0;
    d2 = (n > 2) ? p[2] : 32'h0;
    d3 = (n > 3) ? p[3] : 32'h0;
    ok = (d0[28:24] == 5'd0) && !d0[14] && (u[1:0] == 2'b00) && ((u[8:2] & BAR_MASK) != 7'd0);
`ifndef RX_TLP_PARSER_64BIT_ADDR_EN
    if (d0[29]) ok = 1'b0;
`endif
    hn = d0[29] ? 4 : 3;
    if (!ok || n < hn || (d0[30] && n == hn)) begin
      model_drops = model_drops + 16'd1;
      return;
    end
    a    = d0[29] ? {d2, d3[31:2], 2'b00} : {32'h0, d2[31:2], 2'b00};
    plen = (d0[9:0] == 10'd0) ? 1024 : int'(d0[9:0]);
    if (!d0[30]) begin
      r.addr = a; r.len = 11'(plen); r.tag = d1[15:8]; r.req_id = d1[31:16];
      r.tc = d0[22:20]; r.attr = d0[13:12]; r.fb = d1[3:0]; r.lb = d1[7:4];
      exp_rd.push_back(r);
      if (n > hn) model_drops = model_drops + 16'd1;
      return;
    end
    pay = n - hn;
    for (int i = 0; i < pay && i < plen; i++) begin
      w.addr = a + 64'(4 * i);
      w.data = p[hn + i];
      w.be   = (i == 0) ? d1[3:0] : ((i == plen - 1) ? d1[7:4] : 4'hF);
      w.last = (i == plen - 1) || (i == pay - 1);
      exp_wr.push_back(w);
    end
    if (pay < plen) model_drops = model_drops + 16'd1;
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic last, input logic [21:0] u);
    logic acc;
    int guard;
    guard = 0;
    bus.i_axis_rx_tdata  = d;
    bus.i_axis_rx_tlast  = last;
    bus.i_axis_rx_tuser  = u;
    bus.i_axis_rx_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      acc = bus.o_axis_rx_tready;
      @(posedge clk);
      #1;
      if (acc) break;
      guard++;
      if (guard > 300) begin
        checks++; failures++;
        $display("FAIL tready_timeout actual=0 required=1 t=%0t", $time);
        break;
      end
    end
  endtask

  task automatic send_tlp(input logic [31:0] p[$], input logic [21:0] u);
    for (int i = 0; i < p.size(); i++) send_beat(p[i], (i == p.size() - 1), u);
    bus.i_axis_rx_tvalid = 1'b0;
    bus.i_axis_rx_tlast  = 1'b0;
  endtask

  task automatic run_tlp(input logic [31:0] p[$], input logic [21:0] u, input string name);
    model_tlp(p, u);
    send_tlp(p, u);
    chk({name, "_drop_count"}, 64'(bus.o_drop_count), 64'(model_drops));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_wr.size() != 0 || exp_rd.size() != 0) && guard < 400) begin
      @(posedge clk); #1; guard++;
    end
    chk("drain_wr_queue", 64'(exp_wr.size()), 64'd0);
    chk("drain_rd_queue", 64'(exp_rd.size()), 64'd0);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (wr_mode)
      0:       bus.i_wr_ready = 1'b1;
      1:       bus.i_wr_ready = ~bus.i_wr_ready;
      default: bus.i_wr_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (bus.o_wr_valid) begin
        if (exp_wr.size() == 0) chk("wr_unexpected_valid", 64'(bus.o_wr_valid), 64'd0);
        else begin
          chk("wr_addr", bus.o_wr_addr, exp_wr[0].addr);
          chk("wr_data", 64'(bus.o_wr_data), 64'(exp_wr[0].data));
          chk("wr_be", 64'(bus.o_wr_be), 64'(exp_wr[0].be));
          chk("wr_last", 64'(bus.o_wr_last), 64'(exp_wr[0].last));
          if (bus.i_wr_ready) begin
            got_wr.push_back({bus.o_wr_addr, bus.o_wr_data, bus.o_wr_be, bus.o_wr_last});
            void'(exp_wr.pop_front());
          end
        end
      end
      if (bus.o_rd_valid) begin
        if (exp_rd.size() == 0) chk("rd_unexpected_valid", 64'(bus.o_rd_valid), 64'd0);
        else begin
          chk("rd_addr", bus.o_rd_addr, exp_rd[0].addr);
          chk("rd_len", 64'(bus.o_rd_len), 64'(exp_rd[0].len));
          chk("rd_fields", 64'({bus.o_rd_tag, bus.o_rd_req_id, bus.o_rd_tc, bus.o_rd_attr,
                                bus.o_rd_first_be, bus.o_rd_last_be}),
              64'({exp_rd[0].tag, exp_rd[0].req_id, exp_rd[0].tc, exp_rd[0].attr,
                   exp_rd[0].fb, exp_rd[0].lb}));
          if (bus.i_rd_ready) void'(exp_rd.pop_front());
        end
      end
    end
  end

  initial begin
    bus.i_axis_rx_tdata  = 32'h0;
    bus.i_axis_rx_tkeep  = 4'hF;
    bus.i_axis_rx_tlast  = 1'b0;
    bus.i_axis_rx_tvalid = 1'b0;
    bus.i_axis_rx_tuser  = 22'h0;
    bus.i_wr_ready       = 1'b1;
    bus.i_rd_ready       = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tready", 64'(bus.o_axis_rx_tready), 64'd0);
    chk("reset_wr_valid", 64'(bus.o_wr_valid), 64'd0);
    chk("reset_rd_valid", 64'(bus.o_rd_valid), 64'd0);
    chk("reset_drop_count", 64'(bus.o_drop_count), 64'd0);
    chk("reset_rd_len", 64'(bus.o_rd_len), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("idle_tready", 64'(bus.o_axis_rx_tready), 64'd1);
    @(posedge clk); #1;

    // MWr32 len 4, first_be E, last_be 7
    pkt = '{32'h4000_0004, 32'h0100_017E, 32'h0000_1000, 32'd1, 32'd2, 32'd3, 32'd4};
    run_tlp(pkt, 22'h4, "mwr32");
    drain();
    chk("lit_mwr32_beats", 64'(got_wr.size()), 64'd4);
    if (got_wr.size() == 4) begin
      chk("lit_mwr32_addr0", got_wr[0].addr, 64'h1000);
      chk("lit_mwr32_addr3", got_wr[3].addr, 64'h100C);
      chk("lit_mwr32_be", 64'({got_wr[0].be, got_wr[1].be, got_wr[2].be, got_wr[3].be}), 64'hEFF7);
      chk("lit_mwr32_last", 64'({got_wr[2].last, got_wr[3].last}), 64'b01);
    end
    chk("lit_bar_hit", 64'(bus.o_bar_hit), 64'h01);

    // MRd32 len 0 (1024 DW), descriptor held while rd_ready low
    bus.i_rd_ready = 1'b0;
    pkt = '{32'h0000_0000, 32'h0100_5AFF, 32'h0000_2000};
    run_tlp(pkt, 22'h4, "mrd32");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_tready", 64'(bus.o_axis_rx_tready), 64'd0);
      chk("hold_rd_valid", 64'(bus.o_rd_valid), 64'd1);
      chk("lit_rd_len", 64'(bus.o_rd_len), 64'd1024);
      chk("lit_rd_tag_req", 64'({bus.o_rd_tag, bus.o_rd_req_id}), 64'h5A_0100);
      chk("lit_rd_addr", bus.o_rd_addr, 64'h2000);
    end
    @(posedge clk); #1;
    bus.i_rd_ready = 1'b1;
    drain();

    // Poisoned MWr back-to-back with MWr32 len 1
    got_wr.delete();
    pkt = '{32'h4000_4001, 32'h0100_0003, 32'h0000_3000, 32'hCAFE_0000};
    run_tlp(pkt, 22'h4, "ep_drop");
    chk("lit_ep_drop_count", 64'(bus.o_drop_count), 64'd1);
    pkt = '{32'h4000_0001, 32'h0100_0203, 32'h0000_3000, 32'hDEAD_BEEF};
    run_tlp(pkt, 22'h4, "mwr_len1");
    drain();
    if (got_wr.size() == 1) chk("lit_len1_be", 64'(got_wr[0].be), 64'h3);
    else chk("lit_len1_beats", 64'(got_wr.size()), 64'd1);

    // MWr64 crossing the 4 GiB boundary
    got_wr.delete();
    pkt = '{32'h6000_0002, 32'h0100_03FF, 32'h0000_0001, 32'hFFFF_FFFC, 32'hA, 32'hB};
    run_tlp(pkt, 22'h4, "mwr64");
    drain();
`ifdef RX_TLP_PARSER_64BIT_ADDR_EN
    if (got_wr.size() == 2) begin
      chk("lit_mwr64_addr0", got_wr[0].addr, 64'h1_FFFF_FFFC);
      chk("lit_mwr64_addr1", got_wr[1].addr, 64'h2_0000_0000);
    end else chk("lit_mwr64_beats", 64'(got_wr.size()), 64'd2);
`else
    chk("lit_mwr64_dropped", 64'(bus.o_drop_count), 64'd2);
`endif

    // Early tlast with wr_ready toggling, then a full packet still toggling
    wr_mode = 1;
    pkt = '{32'h4000_0008, 32'h0100_04FF, 32'h0000_4000, 32'h11, 32'h22, 32'h33};
    run_tlp(pkt, 22'h4, "early_tlast");
    pkt = '{32'h4000_0004, 32'h0100_053C, 32'h0000_5000, 32'h51, 32'h52, 32'h53, 32'h54};
    run_tlp(pkt, 22'h4, "toggle_full");
    drain();
    wr_mode = 0;

    // Other discard cases: BAR masked out, completion type, truncated header, read with payload,
    // write with payload longer than its length field
    pkt = '{32'h4000_0001, 32'h0100_000F, 32'h0000_6000, 32'h61};
    run_tlp(pkt, 22'h0, "bar_miss");
    pkt = '{32'h4A00_0001, 32'h0100_0000, 32'h0000_0000, 32'h71};
    run_tlp(pkt, 22'h8, "cpl_type");
    pkt = '{32'h4000_0001, 32'h0100_000F};
    run_tlp(pkt, 22'h4, "short_hdr");
    pkt = '{32'h0010_1001, 32'h0200_330F, 32'h0000_7000, 32'h99};
    run_tlp(pkt, 22'h4, "mrd_payload");
    pkt = '{32'h4000_0001, 32'h0100_000F, 32'h0000_8000, 32'h81, 32'h82};
    run_tlp(pkt, 22'h4, "mwr_overlong");
    pkt = '{32'h0000_0002, 32'h0300_12F1, 32'h0000_9004};
    run_tlp(pkt, 22'h4, "mrd_after_drop");
    drain();

    // Reset in the middle of a write payload
    mon_en = 1'b0;
    wr_mode = 2;
    @(posedge clk); #1;
    send_beat(32'h4000_0008, 1'b0, 22'h4);
    send_beat(32'h0100_01FF, 1'b0, 22'h4);
    send_beat(32'h0000_A000, 1'b0, 22'h4);
    bus.i_axis_rx_tdata = 32'h1234_5678;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_tready", 64'(bus.o_axis_rx_tready), 64'd0);
    @(posedge clk); #1;
    bus.i_axis_rx_tvalid = 1'b0;
    @(negedge clk);
    chk("rst_wr_valid", 64'(bus.o_wr_valid), 64'd0);
    chk("rst_wr_addr", bus.o_wr_addr, 64'd0);
    chk("rst_drop_count", 64'(bus.o_drop_count), 64'd0);
    chk("rst_bar_hit", 64'(bus.o_bar_hit), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wr_mode = 0;
    exp_wr.delete();
    exp_rd.delete();
    model_drops = 16'd0;
    mon_en = 1'b1;
    pkt = '{32'h0020_2004, 32'h0400_77FF, 32'h0000_B000};
    run_tlp(pkt, 22'h10, "mrd_after_rst");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
